// File: rtl/spi_pkg.sv
// Shared types for the SPI byte sequencer: FSM state encoding and the byte type.
package spi_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StWaitLo,
        StWaitHi,
        StCapture
    } seq_state_t;

    typedef logic [7:0] spi_byte_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; an extra count bit separates full from empty.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // A pop frees the slot a same-cycle push needs, so full+push+pop stays full.
    // An empty FIFO ignores the pop, so the push still lands.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + (AW+1)'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/spi_byte_sequencer.sv
// Feeds host bytes to an SPI byte engine one at a time and collects the returned bytes.
// Completion is the engine's chip-select returning high; a start that never lowers it times out.
module spi_byte_sequencer
    import spi_pkg::*;
#(
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned EN_TIMEOUT = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [7:0]                 tx_data_i,
    input  logic                       tx_valid_i,
    output logic                       tx_ready_o,
    output logic [7:0]                 rx_data_o,
    output logic                       rx_valid_o,
    input  logic                       rx_ready_i,
    output logic [7:0]                 spi_data_in_o,
    output logic                       spi_start_o,
    input  logic                       spi_en_i,
    input  logic [7:0]                 spi_data_out_i,
    output logic                       busy_o,
    output logic [$clog2(DEPTH):0]     tx_level_o,
    output logic                       timeout_err_o,
    input  logic                       err_clr_i
);

    localparam int unsigned LW = $clog2(DEPTH) + 1;
    localparam int unsigned CW = $clog2(EN_TIMEOUT + 1);

    seq_state_t      state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    spi_byte_t       data_in_q, data_in_d;
    spi_byte_t       rx_byte_q, rx_byte_d;
    logic            start_q, start_d;
    logic            err_q, err_d;
    logic            timeout;

    logic            tx_full, tx_empty, rx_full, rx_empty;
    logic            tx_push, rx_push, rx_pop, launch;
    spi_byte_t       tx_head;
    logic [LW-1:0]   tx_count;

    assign launch     = (state_q == StIdle) && !tx_empty && !rx_full && spi_en_i;
    // A launch pops the head this cycle, so a full TX can still take a byte.
    assign tx_ready_o = !tx_full || launch;
    assign tx_push    = tx_valid_i && tx_ready_o;
    assign rx_valid_o = !rx_empty;
    assign rx_pop     = rx_valid_o && rx_ready_i;
    assign rx_push    = (state_q == StCapture);

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (DEPTH)
    ) u_tx_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (tx_push),
        .wdata_i (tx_data_i),
        .pop_i   (launch),
        .rdata_o (tx_head),
        .full_o  (tx_full),
        .empty_o (tx_empty),
        .count_o (tx_count)
    );

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (DEPTH)
    ) u_rx_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (rx_push),
        .wdata_i (rx_byte_q),
        .pop_i   (rx_pop),
        .rdata_o (rx_data_o),
        .full_o  (rx_full),
        .empty_o (rx_empty),
        .count_o ()
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        data_in_d = data_in_q;
        rx_byte_d = rx_byte_q;
        err_d     = err_q;
        timeout   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (launch) begin
                    data_in_d = tx_head;
                    state_d   = StStart;
                end
            end
            StStart: begin
                cnt_d   = '0;
                state_d = StWaitLo;
            end
            StWaitLo: begin
                if (!spi_en_i) begin
                    state_d = StWaitHi;
                end else if (cnt_q == CW'(EN_TIMEOUT - 1)) begin
                    timeout = 1'b1;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            StWaitHi: begin
                // The engine updates data_out on the same edge it raises chip-select.
                if (spi_en_i) begin
                    rx_byte_d = spi_data_out_i;
                    state_d   = StCapture;
                end
            end
            StCapture: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (timeout) begin
            err_d = 1'b1;
        end else if (err_clr_i) begin
            err_d = 1'b0;
        end

        start_d = (state_d == StStart);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            data_in_q <= '0;
            rx_byte_q <= '0;
            start_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            data_in_q <= data_in_d;
            rx_byte_q <= rx_byte_d;
            start_q   <= start_d;
            err_q     <= err_d;
        end
    end

    assign spi_data_in_o = data_in_q;
    assign spi_start_o   = start_q;
    assign busy_o        = (state_q != StIdle);
    assign tx_level_o    = tx_count;
    assign timeout_err_o = err_q;

endmodule

// File: tb/tb_spi_byte_sequencer.sv
// Directed bench for spi_byte_sequencer with a behavioural model of the SPI byte engine.
module tb_spi_byte_sequencer;

    localparam int MEcho   = 0;
    localparam int MLoop   = 1;
    localparam int MDead   = 2;
    localparam int MManual = 3;

    logic       clk = 1'b0;
    logic       rst_i;
    logic [7:0] tx_data_i;
    logic       tx_valid_i;
    logic       tx_ready_o;
    logic [7:0] rx_data_o;
    logic       rx_valid_o;
    logic       rx_ready_i;
    logic [7:0] spi_data_in_o;
    logic       spi_start_o;
    logic       spi_en_i;
    logic [7:0] spi_data_out_i;
    logic       busy_o;
    logic [3:0] tx_level_o;
    logic       timeout_err_o;
    logic       err_clr_i;

    int         vectors = 0;
    int         miscompares = 0;
    int         mode = MEcho;
    int         hold_lo = 4;
    int         starts = 0;
    logic       drv_busy = 1'b0;
    logic [7:0] start_log [$];
    int         s0;
    int         busy_cnt;

    always #5 clk = ~clk;

    spi_byte_sequencer #(
        .DEPTH      (8),
        .EN_TIMEOUT (16)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .tx_data_i      (tx_data_i),
        .tx_valid_i     (tx_valid_i),
        .tx_ready_o     (tx_ready_o),
        .rx_data_o      (rx_data_o),
        .rx_valid_o     (rx_valid_o),
        .rx_ready_i     (rx_ready_i),
        .spi_data_in_o  (spi_data_in_o),
        .spi_start_o    (spi_start_o),
        .spi_en_i       (spi_en_i),
        .spi_data_out_i (spi_data_out_i),
        .busy_o         (busy_o),
        .tx_level_o     (tx_level_o),
        .timeout_err_o  (timeout_err_o),
        .err_clr_i      (err_clr_i)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Engine model: lower chip-select 2 cycles after the start pulse, hold, then raise with data.
    initial begin
        logic [7:0] byte_l;
        spi_en_i       = 1'b1;
        spi_data_out_i = 8'h00;
        forever begin
            @(posedge clk);
            #1;
            if (spi_start_o) begin
                starts++;
                start_log.push_back(spi_data_in_o);
                if (mode == MEcho || mode == MLoop) begin
                    byte_l   = spi_data_in_o;
                    drv_busy = 1'b1;
                    repeat (2) @(posedge clk);
                    #1;
                    spi_en_i = 1'b0;
                    repeat (hold_lo) @(posedge clk);
                    #1;
                    spi_data_out_i = (mode == MEcho) ? 8'h3C : byte_l;
                    spi_en_i       = 1'b1;
                    drv_busy       = 1'b0;
                end
            end
        end
    end

    task automatic push(input logic [7:0] b);
        int n = 0;
        while (!tx_ready_o && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n == 100) check("push_ready_wait", 32'(tx_ready_o), 32'd1);
        tx_data_i  = b;
        tx_valid_i = 1'b1;
        @(negedge clk);
        tx_valid_i = 1'b0;
    endtask

    task automatic wait_rx(input int budget);
        int n = 0;
        while (!rx_valid_o && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("rx_valid_wait", 32'(rx_valid_o), 32'd1);
    endtask

    task automatic pop(input string tag, input logic [7:0] exp);
        wait_rx(80);
        check(tag, 32'(rx_data_o), 32'(exp));
        rx_ready_i = 1'b1;
        @(negedge clk);
        rx_ready_i = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((busy_o || tx_level_o != 0 || drv_busy) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("idle_wait", 32'(n < budget), 32'd1);
    endtask

    task automatic wait_starts(input int target, input int budget);
        int n = 0;
        while (starts < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("start_count_wait", 32'(starts), 32'(target));
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_tx_ready"}, 32'(tx_ready_o), 32'd1);
        check({tag, "_rx_valid"}, 32'(rx_valid_o), 32'd0);
        check({tag, "_tx_level"}, 32'(tx_level_o), 32'd0);
        check({tag, "_busy"}, 32'(busy_o), 32'd0);
        check({tag, "_spi_start"}, 32'(spi_start_o), 32'd0);
        check({tag, "_spi_data_in"}, 32'(spi_data_in_o), 32'd0);
        check({tag, "_timeout_err"}, 32'(timeout_err_o), 32'd0);
    endtask

    initial begin
        rst_i      = 1'b1;
        tx_data_i  = 8'h00;
        tx_valid_i = 1'b0;
        rx_ready_i = 1'b0;
        err_clr_i  = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_vals("rst");
        rst_i = 1'b0;
        @(negedge clk);

        // Single byte: launch on the edge after the push, engine answers 0x3C.
        mode = MEcho;
        push(8'hA5);
        check("t1_level_after_push", 32'(tx_level_o), 32'd1);
        @(negedge clk);
        check("t1_start_pulse", 32'(spi_start_o), 32'd1);
        check("t1_data_in", 32'(spi_data_in_o), 32'hA5);
        check("t1_level_after_launch", 32'(tx_level_o), 32'd0);
        @(negedge clk);
        check("t1_start_one_cycle", 32'(spi_start_o), 32'd0);
        check("t1_data_in_held", 32'(spi_data_in_o), 32'hA5);
        wait_rx(40);
        check("t1_starts", 32'(starts), 32'd1);
        pop("t1_rx_data", 8'h3C);
        check("t1_rx_empty", 32'(rx_valid_o), 32'd0);

        // Four bytes back-to-back in loopback: first launches while the second is pushed.
        mode = MLoop;
        s0 = starts;
        for (int i = 1; i <= 4; i++) push(8'(i));
        check("t2_level_after_pushes", 32'(tx_level_o), 32'd3);
        wait_idle(200);
        check("t2_starts", 32'(starts - s0), 32'd4);
        for (int i = 0; i < 4; i++) check("t2_start_order", 32'(start_log[s0 + i]), 32'(i + 1));
        for (int i = 1; i <= 4; i++) pop("t2_rx_order", 8'(i));

        // RX backpressure: 10 bytes, RX fills at 8 and launches stall.
        s0 = starts;
        for (int i = 0; i < 10; i++) push(8'h10 + 8'(i));
        wait_starts(s0 + 8, 400);
        for (int n = 0; n < 40 && busy_o; n++) @(negedge clk);
        repeat (10) @(negedge clk);
        check("t3_starts_stalled", 32'(starts - s0), 32'd8);
        check("t3_tx_level", 32'(tx_level_o), 32'd2);
        check("t3_idle", 32'(busy_o), 32'd0);
        pop("t3_rx_head", 8'h10);
        wait_starts(s0 + 9, 40);
        check("t3_ninth_byte", 32'(start_log[s0 + 8]), 32'h18);
        for (int i = 1; i < 10; i++) pop("t3_rx_order", 8'h10 + 8'(i));
        wait_idle(100);

        // Engine never lowers chip-select: 1 START + 16 WAIT_LO cycles, then abort.
        mode = MDead;
        s0 = starts;
        push(8'h55);
        busy_cnt = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (busy_o) busy_cnt++;
            else if (busy_cnt != 0) break;
        end
        check("t4_busy_cycles", 32'(busy_cnt), 32'd17);
        check("t4_timeout_err", 32'(timeout_err_o), 32'd1);
        check("t4_single_start", 32'(starts - s0), 32'd1);
        repeat (3) @(negedge clk);
        check("t4_no_rx_push", 32'(rx_valid_o), 32'd0);
        check("t4_err_sticky", 32'(timeout_err_o), 32'd1);
        err_clr_i = 1'b1;
        @(negedge clk);
        err_clr_i = 1'b0;
        check("t4_err_cleared", 32'(timeout_err_o), 32'd0);

        // Reset while waiting for chip-select to rise, with 3 bytes still queued.
        mode    = MLoop;
        hold_lo = 30;
        s0 = starts;
        for (int i = 0; i < 4; i++) push(8'h21 + 8'(i));
        repeat (4) @(negedge clk);
        check("t5_in_transfer", 32'(busy_o), 32'd1);
        check("t5_en_low", 32'(spi_en_i), 32'd0);
        check("t5_queued", 32'(tx_level_o), 32'd3);
        rst_i = 1'b1;
        @(negedge clk);
        check_reset_vals("t5_rst");
        rst_i = 1'b0;
        for (int n = 0; n < 60 && drv_busy; n++) @(negedge clk);
        repeat (5) @(negedge clk);
        check("t5_no_capture", 32'(rx_valid_o), 32'd0);
        check("t5_no_relaunch", 32'(starts - s0), 32'd1);
        check("t5_still_idle", 32'(busy_o), 32'd0);
        hold_lo = 4;

        // Full TX with launch blocked; push and launch land on the same edge.
        mode     = MManual;
        spi_en_i = 1'b0;
        s0 = starts;
        for (int i = 0; i < 8; i++) push(8'h30 + 8'(i));
        check("t6_full_level", 32'(tx_level_o), 32'd8);
        check("t6_full_not_ready", 32'(tx_ready_o), 32'd0);
        check("t6_blocked", 32'(busy_o), 32'd0);
        mode       = MLoop;
        spi_en_i   = 1'b1;
        tx_data_i  = 8'h38;
        tx_valid_i = 1'b1;
        #1;
        check("t6_ready_on_launch", 32'(tx_ready_o), 32'd1);
        @(negedge clk);
        tx_valid_i = 1'b0;
        check("t6_level_held", 32'(tx_level_o), 32'd8);
        check("t6_launch_head", 32'(spi_data_in_o), 32'h30);
        for (int i = 0; i < 9; i++) pop("t6_rx_order", 8'h30 + 8'(i));
        wait_idle(200);
        check("t6_starts", 32'(starts - s0), 32'd9);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete, expected completion");
        $fatal(1, "timeout");
    end

endmodule
